aes_key_schedule_seq: RTL
=========================

# aes_key_schedule_seq

Iterative AES key-expansion engine for AES-128, AES-192 and AES-256, with the key length selected per operation at run time. It generates one 32-bit schedule word per clock into an internal round-key store. The store is read one 128-bit round key at a time, in either encryption order or decryption (reversed) order. It replaces the fixed-length, fully combinational schedule in the decryption datapath with an area-lean sequential block shared by the encrypt and decrypt cores.

## Interface
Parameters:
- `MAX_NK`, 8: largest supported key length in 32-bit words. Legal values are 4, 6 and 8; this bounds the key port and the window register.
- `RK_WORDS`, 60: round-key store depth in 32-bit words, equal to 4*(14+1).

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request a new expansion. Sampled only in IDLE.
- `key_len`, in, 2: key length. 00 = 128 (nk=4, nr=10); 01 = 192 (nk=6, nr=12); 10 = 256 (nk=8, nr=14); 11 is reserved.
- `key`, in, 32*MAX_NK: cipher key, MSB-first. Word 0 is in the top 32 bits. Shorter keys are left-aligned and the unused low bits are ignored.
- `busy`, out, 1: expansion in progress.
- `done`, out, 1: one-cycle pulse when the schedule is complete.
- `keys_valid`, out, 1: the store holds a complete schedule.
- `nr`, out, 4: round count of the stored schedule (10, 12 or 14).
- `cfg_err`, out, 1: one-cycle pulse when `start` is seen with `key_len`=11.
- `rk_rd_en`, in, 1: round-key read request.
- `rk_idx`, in, 4: round index.
- `rk_inv`, in, 1: read order. 0 returns round `rk_idx`; 1 returns round `nr`−`rk_idx` (decryption order).
- `rk_valid`, out, 1: read response strobe.
- `rk_data`, out, 128: round key. Schedule word 4r is in the top 32 bits.

## Operation
- States are IDLE, EXPAND and DONE.
- IDLE, `start`=1, legal `key_len`:
  - Latch nk and nr.
  - Write key words 0..nk−1 into the store and into the nk-word sliding window.
  - Set i=nk, phase counter j=0, rcon=0x01.
  - Clear `keys_valid`, set `busy`, go to EXPAND.
- IDLE, `start`=1, `key_len`=11: pulse `cfg_err`, stay in IDLE, leave the store and `keys_valid` untouched.
- EXPAND, one word per cycle:
  - temp = w[i−1].
  - If j==0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon) (shift left; XOR 0x1B if bit 7 was set).
  - Else if nk==8 and j==4: temp = SubWord(temp).
  - w[i] = w[i−nk] ^ temp. Write it to the store and shift it into the window.
  - i increments. j increments and wraps at nk; no divider is used.
- The last word is i = 4*(nr+1)−1, which is 43, 51 or 59. Its write moves the FSM to DONE.
- DONE lasts one cycle: `done`=1, `keys_valid`=1, `busy`=0, then return to IDLE.
- SubWord uses one 4-byte instance of the standard AES S-box.
- Reads are honoured only when `keys_valid`=1 and `busy`=0. Otherwise `rk_rd_en` is ignored and `rk_valid` stays 0.
- The effective round is r = `rk_inv` ? nr−`rk_idx` : `rk_idx`.
  - If `rk_idx`>nr, the response still returns `rk_valid`=1, with `rk_data`=0.
- `start` while busy or in DONE is ignored.
- Reset mid-expansion returns to IDLE and clears `keys_valid`. Store contents are don't-care after reset.

## Timing
- Reset values: `busy`=0, `done`=0, `keys_valid`=0, `cfg_err`=0, `rk_valid`=0, `rk_data`=0, `nr`=10, state IDLE.
- Let start be accepted at edge E0. EXPAND then writes words at edges E1..E(4(nr+1)−nk), which is 40, 46 or 52 edges.
- `done` is high for the one cycle following edge E41, E47 or E53 respectively.
- `busy` is high from E0 until `done` rises.
- Reads have 1-cycle latency: `rk_rd_en` at edge n gives `rk_valid`/`rk_data` at edge n+1. Back-to-back reads are sustained one per cycle.
- `rk_data` holds its value when `rk_valid`=0.
- A `start` on the same cycle that `done` is high is ignored; the FSM is in DONE, not IDLE.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
  - `done` is high 41 cycles after start.
  - Read idx 10, `rk_inv`=0: d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Read idx 0, `rk_inv`=1: the same value.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - `done` at 47 cycles, `nr`=12.
  - Round 12: e98ba06f448c773c8ecc720401002202.
  - Round 0: the first 4 key words.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - `done` at 53 cycles.
  - Round 14: fe4890d1e6188d0b046df344706c631e.
  - Round 1: 1f352c073b6108d72d9810a30914dff4.
- Assert `rst` at cycle 20 of an AES-128 run:
  - `busy`=0 and `keys_valid`=0 next cycle.
  - A read gets no `rk_valid`.
  - A subsequent fresh start completes correctly.
- Reserved `key_len`=11: one-cycle `cfg_err` pulse, `busy` stays 0, the previously stored AES-256 schedule is still readable.
- Back-to-back streaming and range check:
  - Stream reads idx 0..15 with `rk_inv`=1 after AES-128.
  - Expect 11 keys in reverse order, then zeros for idx 11..15, with `rk_valid` every cycle.
  - `start` pulsed during `busy` has no effect on the result.

Source files
------------

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion, one schedule word per clock into a 60-word store.
// Round-key reads return one 128-bit key a cycle later; no backpressure, reads gated until the schedule is complete.
module aes_key_schedule_seq #(
  parameter int MAX_NK   = 8,
  parameter int RK_WORDS = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [32*MAX_NK-1:0]  key,
  output logic                  busy,
  output logic                  done,
  output logic                  keys_valid,
  output logic [3:0]            nr,
  output logic                  cfg_err,
  input  logic                  rk_rd_en,
  input  logic [3:0]            rk_idx,
  input  logic                  rk_inv,
  output logic                  rk_valid,
  output logic [127:0]          rk_data
);

  localparam int AW = $clog2(RK_WORDS);
  localparam int WW = $clog2(MAX_NK);

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t        state;
  logic [31:0]   store [RK_WORDS];
  logic [31:0]   win [MAX_NK];
  logic [31:0]   key_w [MAX_NK];
  logic [3:0]    nk, nk_sel, nr_sel;
  logic [AW-1:0] i, last_i, last_sel;
  logic [2:0]    j;
  logic [7:0]    rcon;
  logic          fin, load, advance;
  logic [31:0]   w_prev, w_old, sub_in, sub_out, temp, w_new;
  logic [3:0]    eff;
  logic [AW-1:0] base;

  always_comb begin
    nk_sel   = 4'd8;
    nr_sel   = 4'd14;
    last_sel = AW'(59);
    case (key_len)
      2'b00:   begin nk_sel = 4'd4; nr_sel = 4'd10; last_sel = AW'(43); end
      2'b01:   begin nk_sel = 4'd6; nr_sel = 4'd12; last_sel = AW'(51); end
      default: ;
    endcase
    for (int k = 0; k < MAX_NK; k++) key_w[WW'(k)] = key[32*(MAX_NK-k)-1 -: 32];
  end

  assign load    = (state == IDLE) && start && (key_len != 2'b11);
  assign advance = (state == EXPAND) && !fin;

  // win[0] is w[i-1], win[nk-1] is w[i-nk]
  always_comb begin
    w_prev  = win[0];
    w_old   = win[WW'(nk - 4'd1)];
    sub_in  = (j == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]], SBOX[sub_in[15:8]], SBOX[sub_in[7:0]]};
    if (j == 3'd0)                   temp = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && j == 3'd4) temp = sub_out;
    else                             temp = w_prev;
    w_new = w_old ^ temp;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < MAX_NK; k++) begin
        if (k < int'(nk_sel)) begin
          store[AW'(k)] <= key_w[WW'(k)];
          win[WW'(k)]   <= key_w[WW'(int'(nk_sel) - 1 - k)];
        end
      end
      nk     <= nk_sel;
      last_i <= last_sel;
      i      <= AW'(nk_sel);
      j      <= 3'd0;
      rcon   <= 8'h01;
      fin    <= 1'b0;
    end else if (advance) begin
      store[i] <= w_new;
      win[0]   <= w_new;
      for (int k = 1; k < MAX_NK; k++) win[WW'(k)] <= win[WW'(k-1)];
      i   <= i + AW'(1);
      j   <= ({1'b0, j} == nk - 4'd1) ? 3'd0 : j + 3'd1;
      fin <= (i == last_i);
      if (j == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      cfg_err    <= 1'b0;
      nr         <= 4'd10;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start && key_len == 2'b11) begin
            cfg_err <= 1'b1;
          end else if (start) begin
            nr         <= nr_sel;
            keys_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          // fin marks that the final word landed on the previous edge
          if (fin) begin
            done       <= 1'b1;
            keys_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign eff  = rk_inv ? nr - rk_idx : rk_idx;
  assign base = AW'({eff, 2'b00});

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_valid <= 1'b0;
      rk_data  <= '0;
    end else if (rk_rd_en && keys_valid && !busy) begin
      rk_valid <= 1'b1;
      rk_data  <= (rk_idx > nr) ? '0 :
                  {store[base], store[base + AW'(1)], store[base + AW'(2)], store[base + AW'(3)]};
    end else begin
      rk_valid <= 1'b0;
    end
  end

endmodule
